// File: rtl/cond_pkg.sv
// Shared definitions for the conditional-execution stage: condition encodings,
// NZCV bit positions and the default counter width.
package cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int CNT_W_DEFAULT = 16;

endpackage

// File: rtl/cond_check.sv
// Purely combinational condition evaluator: decides whether an instruction with
// condition field Cond executes given the architectural flags.
import cond_pkg::*;

module cond_check (
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic n, z, c, v;

    assign n = Flags[FLAG_N];
    assign z = Flags[FLAG_Z];
    assign c = Flags[FLAG_C];
    assign v = Flags[FLAG_V];

    // NV and any unexpected encoding fall through to the default of "not executed"
    always_comb begin
        CondEx = 1'b0;
        case (cond_e'(Cond))
            EQ: CondEx = z;
            NE: CondEx = ~z;
            CS: CondEx = c;
            CC: CondEx = ~c;
            MI: CondEx = n;
            PL: CondEx = ~n;
            VS: CondEx = v;
            VC: CondEx = ~v;
            HI: CondEx = c & ~z;
            LS: CondEx = ~c | z;
            GE: CondEx = (n == v);
            LT: CondEx = (n != v);
            GT: CondEx = ~z & (n == v);
            LE: CondEx = z | (n != v);
            AL: CondEx = 1'b1;
            NV: CondEx = 1'b0;
            default: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution stage: holds NZCV, gates decoder write intents with the
// condition result and keeps saturating executed/skipped instruction counters.
import cond_pkg::*;

module cond_logic #(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    input  logic             BL,
    input  logic             CntClr,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             LinkWrite,
    output logic             CondEx,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] ExecCount,
    output logic [CNT_W-1:0] SkipCount
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [3:0]       flagReg;
    logic [CNT_W-1:0] execReg;
    logic [CNT_W-1:0] skipReg;

    cond_check u_check (
        .Cond   (Cond),
        .Flags  (flagReg),
        .CondEx (CondEx)
    );

    assign PCSrc     = PCS & CondEx;
    assign RegWrite  = RegW & CondEx & ~NoWrite;
    assign MemWrite  = MemW & CondEx;
    assign LinkWrite = BL & CondEx;

    assign Flags     = flagReg;
    assign ExecCount = execReg;
    assign SkipCount = skipReg;

    // The two flag halves update independently; CntClr never blocks a flag write
    always_ff @(posedge clk) begin
        if (reset) begin
            flagReg <= 4'b0000;
            execReg <= '0;
            skipReg <= '0;
        end else begin
            if (FlagW[1] & CondEx) begin
                flagReg[FLAG_N] <= ALUFlags[FLAG_N];
                flagReg[FLAG_Z] <= ALUFlags[FLAG_Z];
            end
            if (FlagW[0] & CondEx) begin
                flagReg[FLAG_C] <= ALUFlags[FLAG_C];
                flagReg[FLAG_V] <= ALUFlags[FLAG_V];
            end
            if (CntClr) begin
                execReg <= '0;
                skipReg <= '0;
            end else if (CondEx) begin
                if (execReg != CNT_MAX) begin
                    execReg <= execReg + CNT_ONE;
                end
            end else begin
                if (skipReg != CNT_MAX) begin
                    skipReg <= skipReg + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_cond_logic.sv
// Scoreboard bench for cond_logic: expected outputs are queued as each
// instruction is driven and compared against the DUT before the next edge.
import cond_pkg::*;

module tb_cond_logic;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       Cond;
    logic [3:0]       ALUFlags;
    logic [1:0]       FlagW;
    logic             PCS, RegW, MemW, NoWrite, BL, CntClr;
    logic             PCSrc, RegWrite, MemWrite, LinkWrite, CondEx;
    logic [3:0]       Flags;
    logic [CNT_W-1:0] ExecCount, SkipCount;

    logic [3:0]       sweepCond;
    logic [3:0]       sweepFlags;
    logic             sweepEx;

    typedef struct {
        logic             pcsrc;
        logic             regwrite;
        logic             memwrite;
        logic             linkwrite;
        logic             condex;
        logic [3:0]       flags;
        logic [CNT_W-1:0] exec;
        logic [CNT_W-1:0] skip;
    } exp_t;

    exp_t             expQ[$];
    logic [3:0]       modelFlags;
    logic [CNT_W-1:0] modelExec;
    logic [CNT_W-1:0] modelSkip;
    int               compared = 0;
    int               mismatched = 0;

    always #5 clk = ~clk;

    cond_logic #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .Cond      (Cond),
        .ALUFlags  (ALUFlags),
        .FlagW     (FlagW),
        .PCS       (PCS),
        .RegW      (RegW),
        .MemW      (MemW),
        .NoWrite   (NoWrite),
        .BL        (BL),
        .CntClr    (CntClr),
        .PCSrc     (PCSrc),
        .RegWrite  (RegWrite),
        .MemWrite  (MemWrite),
        .LinkWrite (LinkWrite),
        .CondEx    (CondEx),
        .Flags     (Flags),
        .ExecCount (ExecCount),
        .SkipCount (SkipCount)
    );

    cond_check sweepCheck (
        .Cond   (sweepCond),
        .Flags  (sweepFlags),
        .CondEx (sweepEx)
    );

    // Condition reference: odd codes are the complement of the even code below them
    function automatic logic modelCond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'b1111) return 1'b0;
        return base ^ c[0];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] c, input logic [3:0] alu, input logic [1:0] fw,
                                 input logic pcs, input logic regw, input logic memw,
                                 input logic nw, input logic bl, input logic clr, input logic rst);
        exp_t e;
        logic ex;
        @(negedge clk);
        Cond = c; ALUFlags = alu; FlagW = fw; PCS = pcs; RegW = regw; MemW = memw;
        NoWrite = nw; BL = bl; CntClr = clr; reset = rst;
        ex          = modelCond(c, modelFlags);
        e.condex    = ex;
        e.pcsrc     = pcs & ex;
        e.regwrite  = regw & ex & ~nw;
        e.memwrite  = memw & ex;
        e.linkwrite = bl & ex;
        e.flags     = modelFlags;
        e.exec      = modelExec;
        e.skip      = modelSkip;
        expQ.push_back(e);
        if (rst) begin
            modelFlags = 4'b0000;
            modelExec  = '0;
            modelSkip  = '0;
        end else begin
            if (fw[1] && ex) modelFlags[3:2] = alu[3:2];
            if (fw[0] && ex) modelFlags[1:0] = alu[1:0];
            if (clr) begin
                modelExec = '0;
                modelSkip = '0;
            end else if (ex) begin
                if (modelExec != {CNT_W{1'b1}}) modelExec = modelExec + 1'b1;
            end else begin
                if (modelSkip != {CNT_W{1'b1}}) modelSkip = modelSkip + 1'b1;
            end
        end
        #2;
        checkScoreboard();
    endtask

    task automatic checkScoreboard();
        exp_t e;
        if (expQ.size() == 0) begin
            checkOutput("queue_empty", 32'd1, 32'd0);
            return;
        end
        e = expQ.pop_front();
        checkOutput("CondEx",    32'(CondEx),    32'(e.condex));
        checkOutput("PCSrc",     32'(PCSrc),     32'(e.pcsrc));
        checkOutput("RegWrite",  32'(RegWrite),  32'(e.regwrite));
        checkOutput("MemWrite",  32'(MemWrite),  32'(e.memwrite));
        checkOutput("LinkWrite", 32'(LinkWrite), 32'(e.linkwrite));
        checkOutput("Flags",     32'(Flags),     32'(e.flags));
        checkOutput("ExecCount", 32'(ExecCount), 32'(e.exec));
        checkOutput("SkipCount", 32'(SkipCount), 32'(e.skip));
    endtask

    initial begin
        reset = 1'b1; Cond = 4'b1110; ALUFlags = 4'b0000; FlagW = 2'b00;
        PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0; BL = 1'b0; CntClr = 1'b0;
        sweepCond = 4'b0000; sweepFlags = 4'b0000;
        repeat (2) @(posedge clk);
        modelFlags = 4'b0000; modelExec = '0; modelSkip = '0;

        //             Cond     ALU      FW     pcs   regw  memw  nw    bl    clr   rst
        applyStimulus(4'b1110, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b1110, 4'b0110, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0001, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b1110, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b1110, 4'b0000, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b1110, 4'b0000, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0000, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'b1111, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'b1110, 4'b1000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b1011, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b1010, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b1100, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b1101, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b1110, 4'b1001, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b1100, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b1110, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++)
            applyStimulus(4'b1110, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++)
            applyStimulus(4'b1111, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Counter clear together with an executing flag-setting instruction
        applyStimulus(4'b1110, 4'b0100, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++)
            applyStimulus(4'($urandom_range(15)), 4'($urandom_range(15)), 2'($urandom_range(3)),
                          1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                          1'($urandom_range(1)), 1'($urandom_range(1)),
                          1'($urandom_range(7) == 0), 1'b0);

        // Mid-program reset: outputs in the reset cycle still use pre-reset flags
        applyStimulus(4'b1110, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(4'b0001, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                sweepCond  = 4'(c);
                sweepFlags = 4'(f);
                #1;
                checkOutput("sweep", 32'(sweepEx), 32'(modelCond(4'(c), 4'(f))));
            end
        end

        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
